// File: rtl/gfx_rect_cmd_queue_pkg.sv
// Shared definitions for the rectangle command queue: screen geometry, command layout,
// FSM encoding and the span clamp helper.
package gfx_pkg;

    localparam int BIT_SIZE      = 10;
    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int COLOR_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2
    } state_e;

    typedef struct packed {
        logic [BIT_SIZE-1:0] x;
        logic [BIT_SIZE-1:0] y;
        logic [BIT_SIZE-1:0] w;
        logic [BIT_SIZE-1:0] h;
        logic [COLOR_W-1:0]  color;
    } rect_cmd_t;

    localparam int CMD_W = $bits(rect_cmd_t);

    // min(len, limit - org) at one extra bit so org+len can never wrap; caller
    // guarantees org < limit.
    function automatic logic [BIT_SIZE-1:0] clamp_span(
        input logic [BIT_SIZE-1:0] org,
        input logic [BIT_SIZE-1:0] len,
        input logic [BIT_SIZE:0]   limit
    );
        logic [BIT_SIZE:0] room;
        logic [BIT_SIZE:0] ext;
        room = limit - {1'b0, org};
        ext  = {1'b0, len};
        return (ext < room) ? len : room[BIT_SIZE-1:0];
    endfunction

endpackage

// File: rtl/gfx_rect_cmd_queue_if.sv
// Command-in / draw-out bus of the rectangle command queue.
interface gfx_rect_cmd_queue_if #(
    parameter int BIT_SIZE = gfx_pkg::BIT_SIZE
);
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [BIT_SIZE-1:0]         cmd_x;
    logic [BIT_SIZE-1:0]         cmd_y;
    logic [BIT_SIZE-1:0]         cmd_w;
    logic [BIT_SIZE-1:0]         cmd_h;
    logic [gfx_pkg::COLOR_W-1:0] cmd_color;

    logic                        draw_enable;
    logic [BIT_SIZE-1:0]         draw_x;
    logic [BIT_SIZE-1:0]         draw_y;
    logic [BIT_SIZE-1:0]         draw_width;
    logic [BIT_SIZE-1:0]         draw_height;
    logic [gfx_pkg::COLOR_W-1:0] draw_color;
    logic                        draw_done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, draw_done,
        input  cmd_ready, draw_enable, draw_x, draw_y, draw_width, draw_height, draw_color
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, draw_done,
        output cmd_ready, draw_enable, draw_x, draw_y, draw_width, draw_height, draw_color
    );
endinterface

// File: rtl/gfx_cmd_fifo.sv
// Synchronous command FIFO; level is the single source of full/empty, read data is
// registered on pop.
module gfx_cmd_fifo
    import gfx_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PTR_BITS = 3,
    parameter int DATA_W   = CMD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic [PTR_BITS:0]   level
);
    localparam logic [PTR_BITS:0] DEPTH_L = (PTR_BITS+1)'(DEPTH);

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   level_q, level_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                do_push, do_pop;

    // A flush swallows a same-cycle push; a full queue never admits one even if popping.
    assign do_push = push & (level_q != DEPTH_L) & ~flush;
    assign do_pop  = pop & (level_q != '0);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (do_pop) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = rd_data_q;
    assign level   = level_q;
endmodule

// File: rtl/gfx_rect_cmd_queue.sv
// Rectangle command queue: buffers draw commands, drops degenerate ones, clamps spans
// to the screen and holds each issued command until the engine reports done.
module gfx_rect_cmd_queue
    import gfx_pkg::*;
#(
    parameter int BIT_SIZE      = gfx_pkg::BIT_SIZE,
    parameter int SCREEN_WIDTH  = gfx_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = gfx_pkg::SCREEN_HEIGHT,
    parameter int FIFO_DEPTH    = 8,
    parameter int PTR_BITS      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gfx_rect_cmd_queue_if.slave  bus,
    input  logic                 flush,
    output logic                 busy,
    output logic [PTR_BITS:0]    level,
    output logic                 cmd_dropped
);
    localparam logic [PTR_BITS:0] DEPTH_L = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [BIT_SIZE:0] SW_L    = (BIT_SIZE+1)'(SCREEN_WIDTH);
    localparam logic [BIT_SIZE:0] SH_L    = (BIT_SIZE+1)'(SCREEN_HEIGHT);

    state_e    state_q, state_d;
    rect_cmd_t draw_q, draw_d;
    logic      draw_en_q, draw_en_d;
    logic      dropped_q, dropped_d;

    rect_cmd_t in_cmd, head;
    logic [CMD_W-1:0] head_raw;
    logic      degenerate;

    assign in_cmd = '{x: bus.cmd_x, y: bus.cmd_y, w: bus.cmd_w, h: bus.cmd_h,
                      color: bus.cmd_color};

    gfx_cmd_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .PTR_BITS (PTR_BITS),
        .DATA_W   (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (bus.cmd_valid),
        .pop     (state_q == ST_IDLE),
        .flush   (flush),
        .wr_data (in_cmd),
        .rd_data (head_raw),
        .level   (level)
    );

    assign head = rect_cmd_t'(head_raw);

    assign degenerate = (head.w == '0) || (head.h == '0) ||
                        ({1'b0, head.x} >= SW_L) || ({1'b0, head.y} >= SH_L);

    always_comb begin
        state_d   = state_q;
        draw_d    = draw_q;
        draw_en_d = draw_en_q;
        dropped_d = 1'b0;
        unique case (state_q)
            // The FIFO pops whenever we sit in IDLE, so head is valid in LOAD.
            ST_IDLE: if (level != '0) state_d = ST_LOAD;
            ST_LOAD: begin
                if (degenerate) begin
                    dropped_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    draw_d.x     = head.x;
                    draw_d.y     = head.y;
                    draw_d.w     = clamp_span(head.x, head.w, SW_L);
                    draw_d.h     = clamp_span(head.y, head.h, SH_L);
                    draw_d.color = head.color;
                    draw_en_d    = 1'b1;
                    state_d      = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (bus.draw_done) begin
                    draw_en_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                draw_en_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            draw_q    <= '0;
            draw_en_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            draw_q    <= draw_d;
            draw_en_q <= draw_en_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.cmd_ready   = (level < DEPTH_L);
    assign bus.draw_enable = draw_en_q;
    assign bus.draw_x      = draw_q.x;
    assign bus.draw_y      = draw_q.y;
    assign bus.draw_width  = draw_q.w;
    assign bus.draw_height = draw_q.h;
    assign bus.draw_color  = draw_q.color;
    assign cmd_dropped     = dropped_q;
    assign busy            = (level != '0) || (state_q != ST_IDLE);
endmodule

// File: tb/tb_gfx_rect_cmd_queue.sv
// Scoreboard bench for gfx_rect_cmd_queue: stimulus queues expected issues/drops, a
// monitor checks them as the DUT presents them.
module tb_gfx_rect_cmd_queue;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       busy, cmd_dropped;
    logic [3:0] level;

    gfx_rect_cmd_queue_if bus ();

    gfx_rect_cmd_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .flush       (flush),
        .busy        (busy),
        .level       (level),
        .cmd_dropped (cmd_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit drop;
        int x, y, w, h, c;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int x, y, w, h, c, input bit exp_en, exp_drop,
                        input int ew, eh);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            cyc(1);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout cmd_ready stuck at 0 expected 1");
            return;
        end
        if (exp_en) sb.push_back('{exp_drop, x, y, ew, eh, c});
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 10'(x);
        bus.cmd_y     = 10'(y);
        bus.cmd_w     = 10'(w);
        bus.cmd_h     = 10'(h);
        bus.cmd_color = 16'(c);
        cyc(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic done_pulse();
        int n = 0;
        while (!bus.draw_enable && n < 200) begin
            cyc(1);
            n++;
        end
        if (!bus.draw_enable) begin
            checks++;
            errors++;
            $display("FAIL done_wait draw_enable stuck at 0 expected 1");
            return;
        end
        cyc(2);
        bus.draw_done = 1'b1;
        cyc(1);
        bus.draw_done = 1'b0;
        chk("enable_low_after_done", bus.draw_enable, 0);
    endtask

    // Monitor: compares every issued rectangle and every drop pulse with the scoreboard.
    initial begin
        logic prev;
        exp_t cur;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (bus.draw_enable && !prev) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue x=%0d got issue expected none", bus.draw_x);
                    end else begin
                        cur = sb.pop_front();
                        chk("issue_kind", 32'(cur.drop), 0);
                        chk("draw_x", bus.draw_x, cur.x);
                        chk("draw_y", bus.draw_y, cur.y);
                        chk("draw_width", bus.draw_width, cur.w);
                        chk("draw_height", bus.draw_height, cur.h);
                        chk("draw_color", bus.draw_color, cur.c);
                    end
                end else if (bus.draw_enable && prev) begin
                    chk("hold_fields", {bus.draw_x, bus.draw_y, bus.draw_width},
                        {2'b0, 10'(cur.x), 10'(cur.y), 10'(cur.w)});
                    chk("hold_color", {bus.draw_height, bus.draw_color}, {10'(cur.h), 16'(cur.c)});
                end
                if (cmd_dropped) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_drop got drop expected none");
                    end else begin
                        cur = sb.pop_front();
                        chk("drop_kind", 32'(cur.drop), 1);
                    end
                end
                prev = bus.draw_enable;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.draw_done = 1'b0;
        cyc(3);
        chk("rst_draw_enable", bus.draw_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_level", level, 0);
        chk("rst_dropped", cmd_dropped, 0);
        chk("rst_draw_fields", {bus.draw_x, bus.draw_y, bus.draw_width, bus.draw_height}, 0);
        rst_n = 1'b1;
        cyc(1);

        // Basic issue with latency check.
        push(10, 20, 100, 50, 16'hF800, 1, 0, 100, 50);
        chk("lat_after_accept", bus.draw_enable, 0);
        chk("busy_after_accept", busy, 1);
        cyc(1);
        chk("lat_load", bus.draw_enable, 0);
        cyc(1);
        chk("lat_draw", bus.draw_enable, 1);
        done_pulse();
        cyc(1);
        chk("idle_gap", bus.draw_enable, 0);

        // Clamping at the screen edges.
        push(600, 470, 100, 50, 16'h07E0, 1, 0, 40, 10);
        done_pulse();
        push(639, 479, 5, 5, 16'h001F, 1, 0, 1, 1);
        done_pulse();
        push(0, 0, 640, 480, 16'h1234, 1, 0, 640, 480);
        done_pulse();

        // Degenerate commands are dropped.
        push(640, 0, 10, 10, 16'hAAAA, 1, 1, 0, 0);
        push(0, 0, 0, 5, 16'h5555, 1, 1, 0, 0);
        cyc(10);
        chk("drop_busy", busy, 0);
        chk("drop_enable", bus.draw_enable, 0);

        // Fill the queue while the first command is held in DRAW.
        for (int i = 1; i <= 8; i++)
            push(i * 10, i * 5, 20 + i, 10 + i, i * 16'h1111, 1, 0, 20 + i, 10 + i);
        chk("fill_level7", level, 7);
        chk("fill_ready7", bus.cmd_ready, 1);
        push(90, 45, 29, 19, 16'h9999, 1, 0, 29, 19);
        chk("fill_level8", level, 8);
        chk("fill_ready8", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 10'd300;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("full_reject_level", level, 8);
        end
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 9; i++) done_pulse();
        cyc(5);
        chk("drain_busy", busy, 0);

        // Flush with one in flight and five queued.
        push(50, 60, 70, 80, 16'hBEEF, 1, 0, 70, 80);
        for (int i = 0; i < 5; i++) push(100 + i, 100, 10, 10, 16'h0F0F, 0, 0, 0, 0);
        chk("pre_flush_level", level, 5);
        chk("pre_flush_enable", bus.draw_enable, 1);
        flush         = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_x     = 10'd7;
        cyc(1);
        flush         = 1'b0;
        bus.cmd_valid = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_inflight", bus.draw_enable, 1);
        done_pulse();
        cyc(10);
        chk("flush_busy", busy, 0);
        chk("flush_no_issue", bus.draw_enable, 0);

        // Reset mid-draw aborts and a late draw_done is ignored.
        push(5, 5, 5, 5, 16'hCAFE, 1, 0, 5, 5);
        push(6, 6, 6, 6, 16'hFACE, 0, 0, 0, 0);
        cyc(2);
        chk("pre_rst_enable", bus.draw_enable, 1);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        chk("midrst_enable", bus.draw_enable, 0);
        chk("midrst_level", level, 0);
        chk("midrst_busy", busy, 0);
        bus.draw_done = 1'b1;
        cyc(1);
        bus.draw_done = 1'b0;
        cyc(3);
        chk("late_done_enable", bus.draw_enable, 0);
        chk("late_done_busy", busy, 0);

        cyc(5);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
